// File: rtl/sync_pkg.sv
// Shared constants and helpers for the multi-bit filtered synchroniser.
// Optional edge outputs are enabled by SYNC_FILTER_EDGE_EN in the top.
package sync_pkg;

  localparam int DEPTH_MIN = 2;

  function automatic int cnt_width(input int stable_cycles);
    int w;
    w = $clog2(stable_cycles + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/sync_chain_bit.sv
// Single-bit DEPTH-stage synchroniser chain with a reset value.
// Plain flop-to-flop path, no logic between stages.
module sync_chain_bit
  import sync_pkg::*;
#(
  parameter int   DEPTH   = 3,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] s;

  always_ff @(posedge clock) begin
    if (reset) begin
      s <= {DEPTH{RST_VAL}};
    end else begin
      s <= {s[DEPTH-2:0], d};
    end
  end

  assign q = s[DEPTH-1];

endmodule

// File: rtl/sync_filter_shift_reg.sv
// Parametrised synchroniser with word-level stability filter.
// Macro SYNC_FILTER_EDGE_EN adds registered io_rise/io_fall outputs.
module sync_filter_shift_reg
  import sync_pkg::*;
#(
  parameter int               WIDTH         = 2,
  parameter int               DEPTH         = 3,
  parameter logic [WIDTH-1:0] INIT          = '0,
  parameter int               STABLE_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] io_d,
  output logic [WIDTH-1:0] io_q,
  output logic             io_changed,
  output logic             io_stable
`ifdef SYNC_FILTER_EDGE_EN
  ,
  output logic [WIDTH-1:0] io_rise,
  output logic [WIDTH-1:0] io_fall
`endif
);

  if (DEPTH < DEPTH_MIN) begin : g_depth_chk
    $error("sync_filter_shift_reg: DEPTH below DEPTH_MIN");
  end
  if (WIDTH < 1) begin : g_width_chk
    $error("sync_filter_shift_reg: WIDTH must be at least 1");
  end

  logic [WIDTH-1:0] synced;
  logic [WIDTH-1:0] nxt;
  logic             commit;
  logic             stable_w;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    sync_chain_bit #(
      .DEPTH  (DEPTH),
      .RST_VAL(INIT[i])
    ) u_bit (
      .clock(clock),
      .reset(reset),
      .d    (io_d[i]),
      .q    (synced[i])
    );
  end

  if (STABLE_CYCLES > 0) begin : g_filt
    localparam int             CW   = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0]  CMAX = CW'(STABLE_CYCLES);

    logic [WIDTH-1:0] cand;
    logic [CW-1:0]    cnt;
    logic             full;

    always_ff @(posedge clock) begin
      if (reset) begin
        cand <= INIT;
        cnt  <= CMAX;
      end else begin
        cand <= synced;
        // any differing bit restarts the whole word
        if (synced != cand) begin
          cnt <= '0;
        end else if (cnt != CMAX) begin
          cnt <= cnt + CW'(1);
        end
      end
    end

    assign full     = (cnt == CMAX);
    assign nxt      = cand;
    assign commit   = full && (cand != io_q);
    assign stable_w = full && (cand == io_q);
  end else begin : g_pass
    assign nxt      = synced;
    assign commit   = (synced != io_q);
    assign stable_w = (synced == io_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      io_q       <= INIT;
      io_changed <= 1'b0;
    end else begin
      io_changed <= commit;
      if (commit) begin
        io_q <= nxt;
      end
    end
  end

  assign io_stable = stable_w;

`ifdef SYNC_FILTER_EDGE_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      io_rise <= '0;
      io_fall <= '0;
    end else if (commit) begin
      io_rise <= nxt & ~io_q;
      io_fall <= ~nxt & io_q;
    end else begin
      io_rise <= '0;
      io_fall <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_sync_filter_shift_reg.sv
// Self-checking bench: vector table, directed corner sequences and
// randomized stimulus against a history-window reference model.
module tb_sync_filter_shift_reg;

  localparam int         AD    = 3;
  localparam int         ASC   = 4;
  localparam logic [1:0] AINIT = 2'b10;
  localparam int         BD    = 2;
  localparam logic [7:0] BINIT = 8'h00;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] da    = AINIT;
  logic [7:0] db    = BINIT;

  logic [1:0] qa;
  logic       cha, sta;
  logic [7:0] qb;
  logic       chb, stb;
`ifdef SYNC_FILTER_EDGE_EN
  logic [1:0] ra, fa;
  logic [7:0] rb, fb;
`endif

  always #5 clock = ~clock;

  sync_filter_shift_reg #(
    .WIDTH(2), .DEPTH(AD), .INIT(AINIT), .STABLE_CYCLES(ASC)
  ) u_a (
    .clock(clock), .reset(reset), .io_d(da),
    .io_q(qa), .io_changed(cha), .io_stable(sta)
`ifdef SYNC_FILTER_EDGE_EN
    , .io_rise(ra), .io_fall(fa)
`endif
  );

  sync_filter_shift_reg #(
    .WIDTH(8), .DEPTH(BD), .INIT(BINIT), .STABLE_CYCLES(0)
  ) u_b (
    .clock(clock), .reset(reset), .io_d(db),
    .io_q(qb), .io_changed(chb), .io_stable(stb)
`ifdef SYNC_FILTER_EDGE_EN
    , .io_rise(rb), .io_fall(fb)
`endif
  );

  int total = 0;
  int bad   = 0;

  // history of the word seen at each rising edge (reset = INIT run)
  logic [1:0] ha[$];
  logic [7:0] hb[$];
  logic [1:0] mqa, mra, mfa;
  logic       mca, msa;
  logic [7:0] mqb, mrb, mfb;
  logic       mcb, msb;

  typedef struct {
    logic       rst;
    logic [1:0] d;
    logic [1:0] q;
    logic       ch;
    logic       st;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic bit win_a(input int lo, input int hi,
                               output logic [1:0] v);
    bit u;
    u = 1'b1;
    v = ha[hi];
    for (int k = lo; k <= hi; k++) if (ha[k] != v) u = 1'b0;
    return u;
  endfunction

  // io_q takes a value once STABLE+1 consecutive synchronised
  // samples agree; the newest sample in the window is DEPTH+1 old.
  task automatic model_edge(input logic r, input logic [1:0] a,
                            input logic [7:0] b);
    int         e, hi;
    bit         u;
    logic [1:0] va, oa;
    logic [7:0] vb, ob;
    if (r) begin
      repeat (16) begin
        ha.push_back(AINIT);
        hb.push_back(BINIT);
      end
    end else begin
      ha.push_back(a);
      hb.push_back(b);
    end
    e  = ha.size() - 1;
    hi = e - AD - 1;
    u  = win_a(hi - ASC, hi, va);
    oa = mqa;
    mra = 2'b00;
    mfa = 2'b00;
    mca = 1'b0;
    if (r) begin
      mqa = AINIT;
    end else if (u && va != oa) begin
      mqa = va;
      mca = 1'b1;
      mra = va & ~oa;
      mfa = ~va & oa;
    end
    u   = win_a(hi + 1 - ASC, hi + 1, va);
    msa = u && (va == mqa);

    e   = hb.size() - 1;
    vb  = hb[e - BD];
    ob  = mqb;
    mrb = 8'h00;
    mfb = 8'h00;
    mcb = 1'b0;
    if (r) begin
      mqb = BINIT;
    end else if (vb != ob) begin
      mqb = vb;
      mcb = 1'b1;
      mrb = vb & ~ob;
      mfb = ~vb & ob;
    end
    msb = (hb[e + 1 - BD] == mqb);
  endtask

  task automatic tick(input logic r, input logic [1:0] a,
                      input logic [7:0] b);
    reset = r;
    da    = a;
    db    = b;
    @(posedge clock);
    model_edge(r, a, b);
    #1;
  endtask

  task automatic chk_model();
    chk("rnd_qa", 8'(qa), 8'(mqa));
    chk("rnd_cha", 8'(cha), 8'(mca));
    chk("rnd_sta", 8'(sta), 8'(msa));
    chk("rnd_qb", qb, mqb);
    chk("rnd_chb", 8'(chb), 8'(mcb));
    chk("rnd_stb", 8'(stb), 8'(msb));
`ifdef SYNC_FILTER_EDGE_EN
    chk("rnd_ra", 8'(ra), 8'(mra));
    chk("rnd_fa", 8'(fa), 8'(mfa));
    chk("rnd_rb", rb, mrb);
    chk("rnd_fb", fb, mfb);
`endif
  endtask

  function automatic void add_hold(input logic [1:0] v, input int n);
    for (int i = 0; i < n; i++) tv.push_back('{1'b0, v, v, 1'b0, 1'b1});
  endfunction

  // a held step commits on the 9th edge; stable drops from edge 4
  function automatic void add_step(input logic [1:0] f,
                                   input logic [1:0] t, input int n);
    for (int i = 1; i <= n; i++)
      tv.push_back('{1'b0, t, (i >= 9) ? t : f, (i == 9),
                     (i < 4) || (i >= 9)});
  endfunction

  initial begin
    bit         dropped;
    int         la, lb;
    logic [1:0] ra_v;
    logic [7:0] rb_v;

    mqa = AINIT; mca = 0; msa = 1; mra = 0; mfa = 0;
    mqb = BINIT; mcb = 0; msb = 1; mrb = 0; mfb = 0;

    tv.push_back('{1'b1, 2'b10, 2'b10, 1'b0, 1'b1});
    add_hold(2'b10, 20);
    add_step(2'b10, 2'b00, 16);
    add_step(2'b00, 2'b11, 16);

    foreach (tv[i]) begin
      tick(tv[i].rst, tv[i].d, 8'h00);
      chk("vec_q", 8'(qa), 8'(tv[i].q));
      chk("vec_changed", 8'(cha), 8'(tv[i].ch));
      chk("vec_stable", 8'(sta), 8'(tv[i].st));
    end

    // short glitch returning to the held value
    repeat (16) tick(1'b0, 2'b00, 8'h00);
    dropped = 1'b0;
    for (int i = 0; i < 23; i++) begin
      tick(1'b0, (i < 3) ? 2'b01 : 2'b00, 8'h00);
      chk("glitch_q", 8'(qa), 8'h00);
      chk("glitch_changed", 8'(cha), 8'h00);
      if (!sta) dropped = 1'b1;
    end
    chk("glitch_stable_dropped", 8'(dropped), 8'h01);
    chk("glitch_stable_back", 8'(sta), 8'h01);

    // continuous toggle, then hold
    for (int i = 1; i <= 50; i++) begin
      tick(1'b0, (i % 2 == 1) ? 2'b01 : 2'b00, 8'h00);
      chk("toggle_q", 8'(qa), 8'h00);
      if (i >= 4) chk("toggle_stable", 8'(sta), 8'h00);
    end
    for (int j = 1; j <= 12; j++) begin
      tick(1'b0, 2'b01, 8'h00);
      chk("hold_q", 8'(qa), (j >= 9) ? 8'h01 : 8'h00);
      chk("hold_changed", 8'(cha), 8'((j == 9)));
    end

    // reset on the edge that would have committed
    repeat (16) tick(1'b0, 2'b00, 8'h00);
    repeat (8) tick(1'b0, 2'b11, 8'h00);
    chk("pend_q", 8'(qa), 8'h00);
    tick(1'b1, 2'b11, 8'h00);
    chk("rst_q", 8'(qa), 8'(AINIT));
    chk("rst_changed", 8'(cha), 8'h00);
    chk("rst_stable", 8'(sta), 8'h01);
    for (int j = 0; j < 12; j++) begin
      tick(1'b0, AINIT, 8'h00);
      chk("post_rst_q", 8'(qa), 8'(AINIT));
      chk("post_rst_changed", 8'(cha), 8'h00);
    end

    // bypass instance: 8'h0F -> 8'hF0
    repeat (6) tick(1'b0, AINIT, 8'h0F);
    chk("b_pre_q", qb, 8'h0F);
    for (int j = 1; j <= 5; j++) begin
      tick(1'b0, AINIT, 8'hF0);
      chk("b_q", qb, (j >= 3) ? 8'hF0 : 8'h0F);
      chk("b_changed", 8'(chb), 8'((j == 3)));
      chk("b_stable", 8'(stb), 8'((j != 2)));
`ifdef SYNC_FILTER_EDGE_EN
      chk("b_rise", rb, (j == 3) ? 8'hF0 : 8'h00);
      chk("b_fall", fb, (j == 3) ? 8'h0F : 8'h00);
`endif
    end

    // randomized runs against the model
    la = 0; lb = 0;
    ra_v = AINIT; rb_v = 8'h00;
    for (int n = 0; n < 900; n++) begin
      if (la == 0) begin
        ra_v = 2'($urandom);
        la   = $urandom_range(1, 12);
      end
      if (lb == 0) begin
        rb_v = 8'($urandom);
        lb   = $urandom_range(1, 5);
      end
      la--;
      lb--;
      tick(($urandom_range(0, 149) == 0), ra_v, rb_v);
      chk_model();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
